// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO bus responder.
// Contents: address-map region codes and register offsets, FSM state enum,
// access-target enum, timer register selector, control bit indices and
// small decode helpers used by the responder and its timer.
package mio_pkg;

   // Upper address nibble selecting the on-block peripheral regions.
   localparam logic [3:0] REGION_GPIO  = 4'hE;
   localparam logic [3:0] REGION_TIMER = 4'hF;

   // Byte offsets inside a region (addr_in[27:0]).
   localparam logic [27:0] OFF_LED  = 28'h000_0000;
   localparam logic [27:0] OFF_SW   = 28'h000_0004;
   localparam logic [27:0] OFF_TVAL = 28'h000_0000;
   localparam logic [27:0] OFF_TCMP = 28'h000_0004;
   localparam logic [27:0] OFF_TCTL = 28'h000_0008;

   // Timer control/status bit positions.
   localparam int CTL_ENABLE  = 0;
   localparam int CTL_PENDING = 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } mio_state_t;

   typedef enum logic [1:0] {
      TGT_RAM,
      TGT_GPIO,
      TGT_TIMER
   } mio_target_t;

   typedef enum logic [1:0] {
      TREG_NONE,
      TREG_VAL,
      TREG_CMP,
      TREG_CTL
   } timer_reg_t;

   // Map the upper address nibble to the access target; everything that is
   // not a peripheral region belongs to RAM.
   function automatic mio_target_t decode_target(input logic [3:0] region);
      mio_target_t t;
      case (region)
         REGION_GPIO:  t = TGT_GPIO;
         REGION_TIMER: t = TGT_TIMER;
         default:      t = TGT_RAM;
      endcase
      return t;
   endfunction

   // Compare a latched word offset (addr[27:2]) with a byte offset constant.
   function automatic logic offset_match(input logic [25:0] word_off,
                                         input logic [27:0] byte_off);
      return ({word_off, 2'b00} == byte_off);
   endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU memory/IO bus between the CPU core (master) and the responder (slave).
// Handshake: the master raises CPU_MIO with mem_w/addr_in/wdata_in stable; the
// slave samples them only while idle, ignores the request lines afterwards and
// answers with MIO_ready high for exactly one cycle. For reads, rdata_out is
// valid in the MIO_ready cycle and holds until the next read completes.
// Signals: CPU_MIO, mem_w, addr_in[31:0], wdata_in[31:0] (master -> slave);
//          rdata_out[31:0], MIO_ready (slave -> master).
interface mio_bus_responder_if;
   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [31:0] rdata_out;
   logic        MIO_ready;

   modport master (
      output CPU_MIO, mem_w, addr_in, wdata_in,
      input  rdata_out, MIO_ready
   );

   modport slave (
      input  CPU_MIO, mem_w, addr_in, wdata_in,
      output rdata_out, MIO_ready
   );
endinterface

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with compare match and sticky pending flag.
// Ports: clk, reset (async, active high); we/sel/wdata register write port;
// rdata combinational read of the selected register; int_out = pending.
// Control register: bit0 enable (RW), bit1 pending (write 1 to clear).
module mio_timer
   import mio_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  timer_reg_t  sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        int_out
);

   logic [31:0] value;
   logic [31:0] compare;
   logic        enable;
   logic        pending;
   logic        match_set;
   logic        w1c;

   assign match_set = enable && (value == compare);
   assign w1c       = we && (sel == TREG_CTL) && wdata[CTL_PENDING];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value   <= '0;
         compare <= 32'hFFFF_FFFF;
         enable  <= 1'b0;
         pending <= 1'b0;
      end else begin
         // A CPU write to the value register overrides the increment.
         if (we && (sel == TREG_VAL))
            value <= wdata;
         else if (enable)
            value <= value + 32'd1;

         if (we && (sel == TREG_CMP))
            compare <= wdata;

         if (we && (sel == TREG_CTL))
            enable <= wdata[CTL_ENABLE];

         // A match in the same cycle as a clear keeps the flag set.
         if (match_set)
            pending <= 1'b1;
         else if (w1c)
            pending <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         TREG_VAL: rdata = value;
         TREG_CMP: rdata = compare;
         TREG_CTL: rdata = {30'd0, pending, enable};
         default:  rdata = '0;
      endcase
   end

   assign int_out = pending;

endmodule

// File: rtl/mio_bus_responder.sv
// Slave end of the CPU memory/IO bus. Latches one request at a time, routes it
// to the data RAM, the GPIO registers (LED, switches) or the timer, and
// returns read data with a one-cycle MIO_ready completion pulse.
// Ports: clk, reset (async, active high); bus (slave modport of the CPU bus);
// ram_addr/ram_din/ram_we/ram_dout RAM side; switches in; led_out register;
// INT timer interrupt level; state_dbg current FSM state.
// RAM read timing: ram_dout is sampled at the end of the RAM_LATENCY-th cycle,
// counting the ACCESS cycle (first cycle ram_addr is presented) as cycle one.
module mio_bus_responder
   import mio_pkg::*;
#(
   parameter int RAM_AW      = 10,
   parameter int RAM_LATENCY = 2
)
(
   input  logic                clk,
   input  logic                reset,
   mio_bus_responder_if.slave  bus,
   output logic [RAM_AW-1:0]   ram_addr,
   output logic [31:0]         ram_din,
   output logic                ram_we,
   input  logic [31:0]         ram_dout,
   input  logic [15:0]         switches,
   output logic [15:0]         led_out,
   output logic                INT,
   output mio_state_t          state_dbg
);

   localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   mio_state_t   state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   // Request latched in IDLE; the bus lines are not looked at again until DONE.
   mio_target_t  tgt_l;
   logic         we_l;
   logic [25:0]  off_l;
   logic [31:0]  wdata_l;

   logic         accept;
   logic         capture_ram;
   logic         capture_periph;
   logic         periph_wr;
   logic         led_we;
   logic         timer_we;
   timer_reg_t   timer_sel;
   logic [31:0]  timer_rdata;
   logic [31:0]  periph_rdata;
   mio_target_t  req_tgt;
   logic         unused_addr_bits;

   assign req_tgt          = decode_target(bus.addr_in[31:28]);
   assign unused_addr_bits = ^bus.addr_in[1:0];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      accept         = 1'b0;
      capture_ram    = 1'b0;
      capture_periph = 1'b0;
      periph_wr      = 1'b0;
      ram_we         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.CPU_MIO) begin
               accept     = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (tgt_l == TGT_RAM) begin
               if (we_l) begin
                  ram_we     = 1'b1;
                  state_next = DONE;
               end else if (RAM_LATENCY == 1) begin
                  capture_ram = 1'b1;
                  state_next  = DONE;
               end else begin
                  cnt_next   = CNT_W'(RAM_LATENCY - 1);
                  state_next = WAIT;
               end
            end else begin
               if (we_l)
                  periph_wr = 1'b1;
               else
                  capture_periph = 1'b1;
               state_next = DONE;
            end
         end
         WAIT: begin
            cnt_next = cnt - 1'b1;
            // Counter reaching zero on this cycle means ram_dout is valid now.
            if (cnt == CNT_W'(1)) begin
               capture_ram = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.MIO_ready = (state == DONE);
   assign state_dbg     = state;

   // ---------------- Peripheral decode ----------------
   assign led_we   = periph_wr && (tgt_l == TGT_GPIO) && offset_match(off_l, OFF_LED);
   assign timer_we = periph_wr && (tgt_l == TGT_TIMER);

   always_comb begin
      timer_sel = TREG_NONE;
      if (tgt_l == TGT_TIMER) begin
         if (offset_match(off_l, OFF_TVAL))
            timer_sel = TREG_VAL;
         else if (offset_match(off_l, OFF_TCMP))
            timer_sel = TREG_CMP;
         else if (offset_match(off_l, OFF_TCTL))
            timer_sel = TREG_CTL;
      end
   end

   always_comb begin
      periph_rdata = '0;
      if (tgt_l == TGT_GPIO) begin
         if (offset_match(off_l, OFF_LED))
            periph_rdata = {16'd0, led_out};
         else if (offset_match(off_l, OFF_SW))
            periph_rdata = {16'd0, switches};
      end else if (tgt_l == TGT_TIMER) begin
         periph_rdata = timer_rdata;
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgt_l         <= TGT_RAM;
         we_l          <= 1'b0;
         off_l         <= '0;
         wdata_l       <= '0;
         ram_addr      <= '0;
         ram_din       <= '0;
         bus.rdata_out <= '0;
         led_out       <= '0;
      end else begin
         if (accept) begin
            tgt_l   <= req_tgt;
            we_l    <= bus.mem_w;
            off_l   <= bus.addr_in[27:2];
            wdata_l <= bus.wdata_in;
            // RAM lines only move for RAM requests so peripheral traffic
            // leaves the RAM interface quiet.
            if (req_tgt == TGT_RAM) begin
               ram_addr <= bus.addr_in[RAM_AW+1:2];
               ram_din  <= bus.wdata_in;
            end
         end
         if (capture_ram)
            bus.rdata_out <= ram_dout;
         else if (capture_periph)
            bus.rdata_out <= periph_rdata;
         if (led_we)
            led_out <= wdata_l[15:0];
      end
   end

   mio_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .we      (timer_we),
      .sel     (timer_sel),
      .wdata   (wdata_l),
      .rdata   (timer_rdata),
      .int_out (INT)
   );

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: vector table for single transactions,
// hand-written sequences for timer interrupt, back-to-back and reset corners.
module tb_mio_bus_responder;
   import mio_pkg::*;

   localparam int RAM_AW      = 10;
   localparam int RAM_LATENCY = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT ----------------
   mio_bus_responder_if bus_if ();

   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic              ram_we;
   logic [31:0]       ram_dout;
   logic [15:0]       switches;
   logic [15:0]       led_out;
   logic              int_line;
   mio_state_t        state_dbg;

   mio_bus_responder #(
      .RAM_AW      (RAM_AW),
      .RAM_LATENCY (RAM_LATENCY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if.slave),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout),
      .switches  (switches),
      .led_out   (led_out),
      .INT       (int_line),
      .state_dbg (state_dbg)
   );

   // RAM model: one register stage, so a read address presented in ACCESS
   // yields data in the following cycle (RAM_LATENCY = 2).
   logic [31:0] mem [0:(1<<RAM_AW)-1] = '{default: 32'h0};
   logic [31:0] ram_q = 32'h0;

   always @(posedge clk) begin
      if (reset)
         mem[9] <= 32'hCAFE_F00D;
      else if (ram_we)
         mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
   end
   assign ram_dout = ram_q;

   // ---------------- scoreboard ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   logic              ram_we_seen;
   logic [RAM_AW-1:0] ram_addr_seen;
   logic [31:0]       ram_din_seen;

   // Starts in the next IDLE cycle; returns on the negedge of the MIO_ready
   // cycle. lat = cycles from the accepting IDLE cycle to MIO_ready.
   task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
      @(negedge clk);
      bus_if.CPU_MIO  = 1'b1;
      bus_if.mem_w    = w;
      bus_if.addr_in  = a;
      bus_if.wdata_in = d;
      @(posedge clk);
      @(negedge clk);
      bus_if.CPU_MIO = 1'b0;
      ram_we_seen   = ram_we;
      ram_addr_seen = ram_addr;
      ram_din_seen  = ram_din;
      lat = 1;
      while (!bus_if.MIO_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = bus_if.rdata_out;
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic        is_ram;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      int          lat;
      int          k;
      logic        seen;

      reset            = 1'b1;
      bus_if.CPU_MIO   = 1'b0;
      bus_if.mem_w     = 1'b0;
      bus_if.addr_in   = '0;
      bus_if.wdata_in  = '0;
      switches         = 16'h5A5A;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // ---- reset values and idle behaviour ----
      check("rst_rdata", bus_if.rdata_out, 32'h0);
      check("rst_ready", {31'd0, bus_if.MIO_ready}, 32'h0);
      check("rst_led", {16'd0, led_out}, 32'h0);
      check("rst_int", {31'd0, int_line}, 32'h0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_din", ram_din, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("idle_ready", {31'd0, bus_if.MIO_ready}, 32'h0);
         check("idle_ram_we", {31'd0, ram_we}, 32'h0);
      end

      // ---- vector table ----
      // name, we, addr, wdata, expected rdata_out, expected latency, RAM target
      vecs.push_back('{"tcmp_rst",   1'b0, 32'hF000_0004, 32'h0,         32'hFFFF_FFFF, 2, 1'b0});
      vecs.push_back('{"tval_rst",   1'b0, 32'hF000_0000, 32'h0,         32'h0000_0000, 2, 1'b0});
      vecs.push_back('{"ram_wr",     1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 2, 1'b1});
      vecs.push_back('{"ram_rd",     1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 3, 1'b1});
      vecs.push_back('{"ram_rd9",    1'b0, 32'h0000_0027, 32'h0,         32'hCAFE_F00D, 3, 1'b1});
      vecs.push_back('{"led_wr",     1'b1, 32'hE000_0000, 32'hABCD_1234, 32'hCAFE_F00D, 2, 1'b0});
      vecs.push_back('{"led_rd",     1'b0, 32'hE000_0000, 32'h0,         32'h0000_1234, 2, 1'b0});
      vecs.push_back('{"sw_rd",      1'b0, 32'hE000_0004, 32'h0,         32'h0000_5A5A, 2, 1'b0});
      vecs.push_back('{"gpio_unm_w", 1'b1, 32'hE000_0008, 32'hFFFF_FFFF, 32'h0000_5A5A, 2, 1'b0});
      vecs.push_back('{"gpio_unm_r", 1'b0, 32'hE000_000C, 32'h0,         32'h0000_0000, 2, 1'b0});
      vecs.push_back('{"led_rd2",    1'b0, 32'hE000_0000, 32'h0,         32'h0000_1234, 2, 1'b0});
      vecs.push_back('{"tmr_unm_r",  1'b0, 32'hF000_000C, 32'h0,         32'h0000_0000, 2, 1'b0});
      vecs.push_back('{"tcmp_wr",    1'b1, 32'hF000_0004, 32'h0000_0077, 32'h0000_0000, 2, 1'b0});
      vecs.push_back('{"tcmp_rd",    1'b0, 32'hF000_0004, 32'h0,         32'h0000_0077, 2, 1'b0});

      foreach (vecs[i]) begin
         bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
         check({vecs[i].name, "_ram_we"}, {31'd0, ram_we_seen}, {31'd0, vecs[i].is_ram & vecs[i].we});
         if (vecs[i].is_ram)
            check({vecs[i].name, "_ram_addr"}, 32'(ram_addr_seen), 32'(vecs[i].addr[RAM_AW+1:2]));
         if (vecs[i].is_ram && vecs[i].we)
            check({vecs[i].name, "_ram_din"}, ram_din_seen, vecs[i].wdata);
      end
      check("led_out", {16'd0, led_out}, 32'h0000_1234);

      // ---- timer interrupt: compare=5, value=0, enable ----
      bus_xfer(1'b1, 32'hF000_0004, 32'd5, rd, lat);
      bus_xfer(1'b1, 32'hF000_0000, 32'd0, rd, lat);
      bus_xfer(1'b1, 32'hF000_0008, 32'd1, rd, lat);
      // value reaches 5 five edges after enable; pending registers one later.
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("int_rise_%0d", i), {31'd0, int_line}, (i == 6) ? 32'd1 : 32'd0);
      end
      bus_xfer(1'b0, 32'hF000_0008, 32'h0, rd, lat);
      check("tctl_rd", rd, 32'h0000_0003);

      // W1C (also disables) -> INT low in the cycle after the write
      bus_xfer(1'b1, 32'hF000_0008, 32'h2, rd, lat);
      check("int_w1c", {31'd0, int_line}, 32'h0);
      bus_xfer(1'b0, 32'hF000_0008, 32'h0, rd, lat);
      check("tctl_rd_clr", rd, 32'h0000_0000);

      // W1C landing on a match: enable at edge E1, clear at E1+3 when value
      // has advanced from 100 to 102.
      bus_xfer(1'b1, 32'hF000_0004, 32'd102, rd, lat);
      bus_xfer(1'b1, 32'hF000_0000, 32'd100, rd, lat);
      bus_xfer(1'b1, 32'hF000_0008, 32'h1, rd, lat);
      check("int_pre_coinc", {31'd0, int_line}, 32'h0);
      bus_xfer(1'b1, 32'hF000_0008, 32'h3, rd, lat);
      check("int_coinc", {31'd0, int_line}, 32'h1);
      @(negedge clk);
      check("int_coinc_hold", {31'd0, int_line}, 32'h1);

      // ---- reset during WAIT of a RAM read ----
      @(negedge clk);
      bus_if.CPU_MIO = 1'b1;
      bus_if.mem_w   = 1'b0;
      bus_if.addr_in = 32'h0000_0024;
      @(negedge clk);
      bus_if.CPU_MIO = 1'b0;
      @(negedge clk);
      check("rst_wait_state", 32'(state_dbg), 32'(WAIT));
      reset = 1'b1;
      #1;
      check("rst_async_state", 32'(state_dbg), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_ready_low", {31'd0, bus_if.MIO_ready}, 32'h0);
         check("rst_no_ram_we", {31'd0, ram_we}, 32'h0);
      end
      check("rst_rdata_clr", bus_if.rdata_out, 32'h0);
      check("rst_int_clr", {31'd0, int_line}, 32'h0);
      bus_xfer(1'b0, 32'h0000_0024, 32'h0, rd, lat);
      check("post_rst_lat", 32'(lat), 32'd3);
      check("post_rst_rdata", rd, 32'hCAFE_F00D);

      // ---- back-to-back: CPU_MIO held high across DONE ----
      @(negedge clk);
      bus_if.CPU_MIO  = 1'b1;
      bus_if.mem_w    = 1'b1;
      bus_if.addr_in  = 32'hE000_0000;
      bus_if.wdata_in = 32'h0000_BEEF;
      k = 0;
      seen = 1'b0;
      while (k < 20 && !seen) begin
         @(negedge clk);
         k++;
         // late change of the request lines must not affect this write
         if (k == 1)
            bus_if.wdata_in = 32'h1111_1111;
         if (bus_if.MIO_ready)
            seen = 1'b1;
      end
      check("b2b_first_lat", 32'(k), 32'd2);
      bus_if.mem_w   = 1'b0;
      bus_if.addr_in = 32'h0000_0024;
      k = 0;
      seen = 1'b0;
      while (k < 20 && !seen) begin
         @(negedge clk);
         k++;
         if (k == 2)
            bus_if.CPU_MIO = 1'b0;
         if (bus_if.MIO_ready)
            seen = 1'b1;
      end
      check("b2b_gap", 32'(k), 32'd4);
      check("b2b_rdata", bus_if.rdata_out, 32'hCAFE_F00D);
      check("b2b_led", {16'd0, led_out}, 32'h0000_BEEF);
      @(negedge clk);
      check("b2b_ready_1cyc", {31'd0, bus_if.MIO_ready}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
